fft_result_reader: RTL and testbench
====================================

FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter N, default 16, is the number of FFT bins and SHALL be a power of two, 4 or more.
REQ-002 Parameter MSB, default 16, is the bin word width; upper MSB/2 bits are real, lower MSB/2 bits are imag, both two's complement.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 fft_finish  in  1  one-cycle pulse from the fft block: results are ready.
REQ-006 fft_data  in  MSB  bin word returned combinationally by the fft block for fft_addr.
REQ-007 fft_addr  out  clog2(N)  bin address driven to the fft block addr input.
REQ-008 fft_insert  out  1  drives the fft block insert_data input; held 0 at all times.
REQ-009 mag_data  out  MSB/2+1  |re|+|im| magnitude estimate of the current bin.
REQ-010 mag_bin  out  clog2(N)  bin index of mag_data.
REQ-011 mag_valid  out  1  mag_data/mag_bin/mag_last are valid.
REQ-012 mag_ready  in  1  downstream accepts; a transfer occurs when mag_valid and mag_ready are both 1.
REQ-013 mag_last  out  1  marks bin N-1.
REQ-014 peak_bin  out  clog2(N), and peak_mag  out  MSB/2+1  carry the largest magnitude of the last frame and its bin.
REQ-015 peak_valid  out  1  one-cycle pulse when peak_bin/peak_mag are updated.
REQ-016 busy  out  1  high from frame start until the frame has finished draining.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE: fft_addr=0 and busy=0; on fft_finish=1 the FSM SHALL enter READ, set busy=1, and clear the running peak to 0/bin 0.
REQ-019 READ: a bin is captured when mag_valid=0 or mag_ready=1. Capture loads the output register with mag=|re|+|im| of fft_data, mag_bin=fft_addr, mag_last=(fft_addr==N-1) and mag_valid=1.
REQ-020 On each capture with fft_addr<N-1, fft_addr SHALL increment by 1.
REQ-021 On capture with fft_addr==N-1, fft_addr SHALL hold at N-1 and the FSM SHALL enter DRAIN.
REQ-022 When not capturing, fft_addr and the output register SHALL hold (backpressure); no bin is skipped or duplicated.
REQ-023 When a transfer occurs with no new capture in the same cycle, mag_valid SHALL clear.
REQ-024 Throughput SHALL be one bin per cycle while mag_ready=1; latency from address to mag_valid is 1 cycle.
REQ-025 Abs arithmetic SHALL be exact at MSB/2+1 bits: abs(-2^(MSB/2-1)) = 2^(MSB/2-1), with no overflow; the maximum sum is 2^(MSB/2).
REQ-026 Peak tracking at each capture: the peak updates only if mag is strictly greater than the running peak, so ties keep the lowest bin.
REQ-027 DRAIN: when the mag_last word is transferred, the FSM SHALL enter DONE.
REQ-028 DONE lasts one cycle: peak_valid=1, busy=0, fft_addr returns to 0, then IDLE.
REQ-029 fft_finish received in READ, DRAIN or DONE SHALL be ignored.
REQ-030 Total frame time with mag_ready held at 1 SHALL be N+2 cycles from fft_finish to peak_valid.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, fft_addr=0, mag_valid=0, mag_last=0, mag_data=0, mag_bin=0, peak_bin=0, peak_mag=0, peak_valid=0, busy=0; an in-progress frame is discarded.
REQ-032 rst SHALL take priority over fft_finish in the same cycle.

Structure
REQ-033 A shared package SHALL hold the state encoding constants (IDLE=2'b00, READ=2'b01, DRAIN=2'b10, DONE=2'b11) and the bin word field split (real = upper half, imag = lower half).
REQ-034 A combinational sub-module cplx_mag_l1 (MSB in, MSB/2+1 out) SHALL compute |re|+|im|; everything else is in the top-level FSM.

Verification
REQ-035 Sequence: N=16, bin k = re k, im -k; fft_finish pulse; mag_ready=1 -> mags 0,2,...,30 on consecutive cycles; mag_last on bin 15; peak_bin=15, peak_mag=30; peak_valid 18 cycles after fft_finish.
REQ-036 Extremes: bin 5 = re -128, im -128, all others 0 -> mag_data=256 at bin 5; peak_bin=5, peak_mag=256.
REQ-037 Backpressure: mag_ready toggles 1,0,0,1,... -> all 16 bins delivered exactly once in order; fft_addr holds during stalls.
REQ-038 Ties: bins 3 and 9 both magnitude 40, all others less -> peak_bin=3.
REQ-039 Second fft_finish pulse at cycle 4 of READ -> ignored; frame completes normally with exactly 16 transfers.
REQ-040 rst asserted mid-READ at bin 7 -> next cycle all outputs at reset values; a new fft_finish starts a fresh frame at bin 0.

Source files
------------

// File: rtl/fft_result_reader_pkg.sv
// Shared types and constants for the FFT result reader.
// Holds the FSM encoding and the bin word field split.
package fft_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEF_N   = 16;
  localparam int DEF_MSB = 16;

  // Imag part sits in the low half of a bin word.
  localparam int IM_LSB = 0;

  // Real part sits in the upper half of a bin word.
  function automatic int re_lsb(input int msb);
    return msb / 2;
  endfunction

endpackage

// File: rtl/fft_result_reader_cplx_mag_l1.sv
// L1 magnitude |re|+|im| of a packed complex bin word.
// Output is one bit wider than a half so abs(min) is exact.
module cplx_mag_l1
  import fft_result_reader_pkg::*;
#(
  parameter int MSB = DEF_MSB
) (
  input  logic [MSB-1:0] data,
  output logic [MSB/2:0] mag
);

  localparam int H = MSB / 2;

  logic signed [H-1:0] re;
  logic signed [H-1:0] im;
  logic signed [H:0]   re_x;
  logic signed [H:0]   im_x;
  logic        [H:0]   re_abs;
  logic        [H:0]   im_abs;

  assign re   = data[re_lsb(MSB) +: H];
  assign im   = data[IM_LSB +: H];
  assign re_x = re;
  assign im_x = im;

  assign re_abs = re_x[H] ? -re_x : re_x;
  assign im_abs = im_x[H] ? -im_x : im_x;

  assign mag = re_abs + im_abs;

endmodule

// File: rtl/fft_result_reader.sv
// Streams FFT bins out as L1 magnitudes with backpressure.
// Tracks the per-frame peak and pulses it once per frame.
module fft_result_reader
  import fft_result_reader_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int MSB = DEF_MSB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_finish,
  input  logic [MSB-1:0]       fft_data,
  output logic [$clog2(N)-1:0] fft_addr,
  output logic                 fft_insert,
  output logic [MSB/2:0]       mag_data,
  output logic [$clog2(N)-1:0] mag_bin,
  output logic                 mag_valid,
  input  logic                 mag_ready,
  output logic                 mag_last,
  output logic [$clog2(N)-1:0] peak_bin,
  output logic [MSB/2:0]       peak_mag,
  output logic                 peak_valid,
  output logic                 busy
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t       state;
  state_t       state_nx;
  logic [MSB/2:0] mag;
  logic         capture;
  logic         xfer;
  logic         at_last;

  cplx_mag_l1 #(
    .MSB(MSB)
  ) u_mag (
    .data(fft_data),
    .mag (mag)
  );

  assign fft_insert = 1'b0;
  assign xfer       = mag_valid && mag_ready;
  assign at_last    = fft_addr == LAST;

  // Next state, capture strobe and status outputs.
  always_comb begin
    state_nx   = state;
    capture    = 1'b0;
    busy       = 1'b0;
    peak_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (fft_finish) state_nx = READ;
      end
      READ: begin
        busy    = 1'b1;
        capture = !mag_valid || mag_ready;
        if (capture && at_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (xfer && mag_last) state_nx = DONE;
      end
      DONE: begin
        peak_valid = 1'b1;
        state_nx   = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Address, output register and running peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      fft_addr  <= '0;
      mag_data  <= '0;
      mag_bin   <= '0;
      mag_valid <= 1'b0;
      mag_last  <= 1'b0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fft_finish) begin
            fft_addr <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
          end
        end
        READ: begin
          if (capture) begin
            mag_data  <= mag;
            mag_bin   <= fft_addr;
            mag_last  <= at_last;
            mag_valid <= 1'b1;
            if (mag > peak_mag) begin
              peak_mag <= mag;
              peak_bin <= fft_addr;
            end
            if (!at_last) fft_addr <= fft_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (xfer) mag_valid <= 1'b0;
        end
        DONE: begin
          fft_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader with an FFT memory model.
// Covers ramp, extremes, backpressure, ties, re-trigger, reset.
module tb_fft_result_reader;

  logic        clk;
  logic        rst;
  logic        fft_finish;
  logic [15:0] fft_data;
  logic [3:0]  fft_addr;
  logic        fft_insert;
  logic [8:0]  mag_data;
  logic [3:0]  mag_bin;
  logic        mag_valid;
  logic        mag_ready;
  logic        mag_last;
  logic [3:0]  peak_bin;
  logic [8:0]  peak_mag;
  logic        peak_valid;
  logic        busy;

  logic [15:0] mem [16];
  int          exp_mag [16];
  int          checks = 0;
  int          errors = 0;

  assign fft_data = mem[fft_addr];

  fft_result_reader #(
    .N  (16),
    .MSB(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fft_finish(fft_finish),
    .fft_data  (fft_data),
    .fft_addr  (fft_addr),
    .fft_insert(fft_insert),
    .mag_data  (mag_data),
    .mag_bin   (mag_bin),
    .mag_valid (mag_valid),
    .mag_ready (mag_ready),
    .mag_last  (mag_last),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .peak_valid(peak_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, fft_addr, 0);
    check({tag, "_valid"}, mag_valid, 0);
    check({tag, "_last"}, mag_last, 0);
    check({tag, "_data"}, mag_data, 0);
    check({tag, "_bin"}, mag_bin, 0);
    check({tag, "_pbin"}, peak_bin, 0);
    check({tag, "_pmag"}, peak_mag, 0);
    check({tag, "_pvalid"}, peak_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic frame(input int mode, input int pb,
                       input int pm, input bit dbl);
    int         cyc;
    int         got;
    bit         done;
    bit         stall;
    logic [3:0] sa;
    cyc  = 0;
    got  = 0;
    done = 0;
    while (!done && cyc < 200) begin
      fft_finish = (cyc == 0) || (dbl && cyc == 5);
      mag_ready  = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mag_valid && mag_ready) begin
        if (got < 16) begin
          check("bin", mag_bin, got);
          check("mag", mag_data, exp_mag[got]);
          check("last", mag_last, got == 15);
        end else begin
          check("extra_xfer", got, 15);
        end
        got++;
      end
      stall = mag_valid && !mag_ready;
      sa    = fft_addr;
      step();
      cyc++;
      if (stall) check("addr_hold", fft_addr, sa);
      if (cyc == 1) check("busy_start", busy, 1);
      if (peak_valid) begin
        done = 1;
        check("xfer_count", got, 16);
        check("peak_bin", peak_bin, pb);
        check("peak_mag", peak_mag, pm);
        check("busy_done", busy, 0);
        if (mode == 0) check("frame_time", cyc, 18);
      end
    end
    fft_finish = 1'b0;
    check("timeout", done, 1);
    mag_ready = 1'b1;
    step();
    check("idle_addr", fft_addr, 0);
    check("idle_pvalid", peak_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", mag_valid, 0);
    check("insert", fft_insert, 0);
  endtask

  initial begin
    rst        = 1'b1;
    fft_finish = 1'b0;
    mag_ready  = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0000;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // Ramp: re k, im -k gives 2k, peak at the last bin.
    for (int k = 0; k < 16; k++) begin
      mem[k]     = {8'(k), 8'(-k)};
      exp_mag[k] = 2 * k;
    end
    frame(0, 15, 30, 0);

    // Extremes: most negative re and im in one bin.
    for (int k = 0; k < 16; k++) begin
      mem[k]     = 16'h0000;
      exp_mag[k] = 0;
    end
    mem[5]     = 16'h8080;
    exp_mag[5] = 256;
    frame(0, 5, 256, 0);

    // Backpressure on the ramp data.
    for (int k = 0; k < 16; k++) begin
      mem[k]     = {8'(k), 8'(-k)};
      exp_mag[k] = 2 * k;
    end
    frame(1, 15, 30, 0);

    // Re-trigger during READ is ignored.
    frame(0, 15, 30, 1);

    // Ties: bins 3 and 9 both reach 40.
    for (int k = 0; k < 16; k++) begin
      mem[k]     = {8'(k), 8'h00};
      exp_mag[k] = k;
    end
    mem[3]     = {8'd20, 8'hEC};
    exp_mag[3] = 40;
    mem[9]     = {8'hD8, 8'h00};
    exp_mag[9] = 40;
    frame(0, 3, 40, 0);

    // Reset in the middle of READ.
    mag_ready  = 1'b1;
    fft_finish = 1'b1;
    step();
    fft_finish = 1'b0;
    for (int i = 0; i < 20 && fft_addr != 4'd7; i++) step();
    check("reach_bin7", fft_addr, 7);
    check("busy_mid", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    frame(0, 3, 40, 0);

    // Reset wins over a simultaneous start.
    rst        = 1'b1;
    fft_finish = 1'b1;
    step();
    rst        = 1'b0;
    fft_finish = 1'b0;
    check("rst_prio_busy", busy, 0);
    step();
    check("rst_prio_idle", busy, 0);
    check("rst_prio_valid", mag_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
